// File: rtl/inst_enc_if.sv
// Handshake and field bundle between a decoded-field producer and inst_enc.
// The encoder uses the slave side. The producer and consumer use the master side.
interface inst_enc_if #(
  parameter int INST_NUM_WIDTH = 4,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int IMM_WIDTH      = 32,
  parameter int ISA_WIDTH      = 32,
  parameter int CNT_W          = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic [INST_NUM_WIDTH-1:0] inst_num;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;
  logic [IMM_WIDTH-1:0]      imm;
  logic                      out_valid;
  logic                      out_ready;
  logic [ISA_WIDTH-1:0]      inst;
  logic                      err;
  logic                      err_sticky;
  logic [CNT_W-1:0]          enc_count;

  modport master (
    output in_valid, inst_num, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, inst, err, err_sticky, enc_count
  );

  modport slave (
    input  in_valid, inst_num, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, inst, err, err_sticky, enc_count
  );
endinterface

// File: rtl/inst_enc.sv
// RV32I instruction encoder (add/addi/lb/sb/beq/ebreak) with a 2-entry output FIFO.
// The FIFO is built as head and tail registers so that inst keeps its last word
// once the FIFO drains. Illegal fields are consumed, not pushed, and they pulse err.
module inst_enc #(
  parameter int DEPTH          = 2,
  parameter int CNT_W          = 32,
  parameter int INST_NUM_WIDTH = 4
) (
  input logic        clk,
  input logic        rst,
  inst_enc_if.slave  bus
);

  localparam logic [INST_NUM_WIDTH-1:0] OP_ADD    = INST_NUM_WIDTH'(1);
  localparam logic [INST_NUM_WIDTH-1:0] OP_ADDI   = INST_NUM_WIDTH'(2);
  localparam logic [INST_NUM_WIDTH-1:0] OP_BEQ    = INST_NUM_WIDTH'(3);
  localparam logic [INST_NUM_WIDTH-1:0] OP_LB     = INST_NUM_WIDTH'(4);
  localparam logic [INST_NUM_WIDTH-1:0] OP_SB     = INST_NUM_WIDTH'(5);
  localparam logic [INST_NUM_WIDTH-1:0] OP_EBREAK = INST_NUM_WIDTH'(6);
  localparam logic [2:0]                F3        = 3'b000;

  logic signed [31:0] imm_s;
  logic               imm12_ok;
  logic               imm13_ok;
  logic [31:0]        word;
  logic               legal;
  logic               accept;
  logic               push;
  logic               pop;

  logic [1:0]         count_q, count_d;
  logic [31:0]        head_q, head_d;
  logic [31:0]        tail_q, tail_d;
  logic               err_q, err_d;
  logic               err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]   enc_count_q, enc_count_d;

  assign imm_s    = bus.imm;
  assign imm12_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign imm13_ok = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm_s[0];

  // Build the instruction word and its legality from the current fields
  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (bus.inst_num)
      OP_ADD: begin
        word  = {7'b0, bus.rs2, bus.rs1, F3, bus.rd, 7'b0110011};
        legal = 1'b1;
      end
      OP_ADDI: begin
        word  = {imm_s[11:0], bus.rs1, F3, bus.rd, 7'b0010011};
        legal = imm12_ok;
      end
      OP_LB: begin
        word  = {imm_s[11:0], bus.rs1, F3, bus.rd, 7'b0000011};
        legal = imm12_ok;
      end
      OP_SB: begin
        word  = {imm_s[11:5], bus.rs2, bus.rs1, F3, imm_s[4:0], 7'b0100011};
        legal = imm12_ok;
      end
      OP_BEQ: begin
        word  = {imm_s[12], imm_s[10:5], bus.rs2, bus.rs1, F3, imm_s[4:1], imm_s[11], 7'b1100011};
        legal = imm13_ok;
      end
      OP_EBREAK: begin
        word  = 32'h0010_0073;
        legal = 1'b1;
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  assign bus.in_ready   = (count_q < 2'd2);
  assign bus.out_valid  = (count_q != 2'd0);
  assign bus.inst       = head_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.enc_count  = enc_count_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && legal;
  assign pop    = bus.out_valid && bus.out_ready;

  // FIFO occupancy, head/tail movement, error flags and push counter
  always_comb begin
    count_d      = count_q;
    head_d       = head_q;
    tail_d       = tail_q;
    err_d        = accept && !legal;
    err_sticky_d = err_sticky_q || (accept && !legal);
    enc_count_d  = enc_count_q + CNT_W'(push);
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = word;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = word;
        end else if (push) begin
          tail_d  = word;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        // in_ready is low here, so a pop is the only possible change
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= 2'd0;
      head_q       <= '0;
      tail_q       <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      enc_count_q  <= '0;
    end else begin
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      enc_count_q  <= enc_count_d;
    end
  end

endmodule
